phase_scheduler: RTL and testbench

Signal-phase controller for the intersection. Latches pedestrian and turn requests, arbitrates between them, and sequences the up/down/turn/pedestrian signal heads through yellow and all-red clearance intervals. Outputs drive the intersection's signal heads directly. By construction, outputs always satisfy two rules: pedestrian green excludes up/down green, and turn green excludes down green.

---
 rtl/phase_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_phase_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/phase_scheduler.sv
// phase_scheduler
//
// Signal-phase controller for one intersection. Pedestrian and turn requests
// are latched into pending flags and arbitrated only at the end of the main
// green minimum. The served phase is then sequenced through its yellow (and,
// for the pedestrian path, all-red) clearance intervals before main green resumes.
//
// The machine is Moore. Every head output is decoded from the registered state
// only. The wait flags are registers. No input reaches an output in the same cycle.
// The state table only contains head combinations where pedestrian green never
// overlaps up/down green, and turn green never overlaps down green.
//
// Request handling: pedestrian_button and turn_sensor are plain level inputs,
// with no handshake. Any cycle in which one is high sets its pending flag.
// A flag stays set until its green phase is entered. It is also held clear
// for every cycle spent in that green phase.
//
// Ports
//   clock              rising-edge clock
//   reset              synchronous, active-high; returns to main green
//   pedestrian_button  level request for the pedestrian phase
//   turn_sensor        level request for the protected turn phase
//   up_green .. turn_yellow, pedestrian_green   signal head drives
//   ped_wait, turn_wait  registered pending-request flags
//   state_dbg          current phase state encoding (observation only)
module phase_scheduler #(
  parameter int MAIN_MIN    = 8,
  parameter int TURN_TIME   = 4,
  parameter int PED_TIME    = 6,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int TIMER_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pedestrian_button,
  input  logic       turn_sensor,
  output logic       up_green,
  output logic       down_green,
  output logic       turn_green,
  output logic       pedestrian_green,
  output logic       up_yellow,
  output logic       down_yellow,
  output logic       turn_yellow,
  output logic       ped_wait,
  output logic       turn_wait,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    DOWN_YELLOW = 3'd1,
    TURN_GREEN  = 3'd2,
    TURN_YELLOW = 3'd3,
    MAIN_YELLOW = 3'd4,
    ALL_RED_IN  = 3'd5,
    PED_WALK    = 3'd6,
    ALL_RED_OUT = 3'd7
  } state_t;

  // Timer reload values: each state lasts exactly its dwell in cycles.
  localparam logic [TIMER_W-1:0] MAIN_LOAD   = TIMER_W'(MAIN_MIN - 1);
  localparam logic [TIMER_W-1:0] TURN_LOAD   = TIMER_W'(TURN_TIME - 1);
  localparam logic [TIMER_W-1:0] PED_LOAD    = TIMER_W'(PED_TIME - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LOAD = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LOAD = TIMER_W'(ALLRED_TIME - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

  state_t             state;
  state_t             state_next;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic               timer_done;
  logic               ped_wait_next;
  logic               turn_wait_next;
  // 1 when the pedestrian phase was the last one granted, 0 for turn.
  logic               last_ped;
  logic               last_ped_next;
  logic               grant_ped;
  logic               grant_turn;

  function automatic logic [TIMER_W-1:0] load_for(input state_t s);
    logic [TIMER_W-1:0] v;
    v = MAIN_LOAD;
    case (s)
      MAIN_GREEN:                          v = MAIN_LOAD;
      TURN_GREEN:                          v = TURN_LOAD;
      PED_WALK:                            v = PED_LOAD;
      DOWN_YELLOW, TURN_YELLOW,
      MAIN_YELLOW:                         v = YELLOW_LOAD;
      ALL_RED_IN, ALL_RED_OUT:             v = ALLRED_LOAD;
      default:                             v = MAIN_LOAD;
    endcase
    return v;
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= MAIN_GREEN;
      timer     <= MAIN_LOAD;
      ped_wait  <= 1'b0;
      turn_wait <= 1'b0;
      last_ped  <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      ped_wait  <= ped_wait_next;
      turn_wait <= turn_wait_next;
      last_ped  <= last_ped_next;
    end
  end

  // Next state, timer, flags and arbitration
  always_comb begin
    state_next    = state;
    last_ped_next = last_ped;
    timer_done    = (timer == '0);

    // The arbiter uses only the registered flags. On a tie, the phase that
    // was not served last wins, so the two phases alternate.
    grant_ped  = ped_wait  & (~turn_wait | ~last_ped);
    grant_turn = turn_wait & (~ped_wait  |  last_ped);

    case (state)
      MAIN_GREEN: begin
        if (timer_done) begin
          if (grant_turn) begin
            state_next    = DOWN_YELLOW;
            last_ped_next = 1'b0;
          end else if (grant_ped) begin
            state_next    = MAIN_YELLOW;
            last_ped_next = 1'b1;
          end
        end
      end
      DOWN_YELLOW: if (timer_done) state_next = TURN_GREEN;
      TURN_GREEN:  if (timer_done) state_next = TURN_YELLOW;
      TURN_YELLOW: if (timer_done) state_next = MAIN_GREEN;
      MAIN_YELLOW: if (timer_done) state_next = ALL_RED_IN;
      ALL_RED_IN:  if (timer_done) state_next = PED_WALK;
      PED_WALK:    if (timer_done) state_next = ALL_RED_OUT;
      ALL_RED_OUT: if (timer_done) state_next = MAIN_GREEN;
      default:     state_next = MAIN_GREEN;
    endcase

    // Reload on every state change. Otherwise count down. The count only
    // stays at zero in main green, because every other state leaves at zero.
    if (state_next != state) begin
      timer_next = load_for(state_next);
    end else if (!timer_done) begin
      timer_next = timer - TIMER_ONE;
    end else begin
      timer_next = timer;
    end

    // The flag is cleared on the edge into the served green. It is held
    // clear while that green is active, so requests during it are ignored.
    if (state == PED_WALK || state_next == PED_WALK) begin
      ped_wait_next = 1'b0;
    end else begin
      ped_wait_next = ped_wait | pedestrian_button;
    end

    if (state == TURN_GREEN || state_next == TURN_GREEN) begin
      turn_wait_next = 1'b0;
    end else begin
      turn_wait_next = turn_wait | turn_sensor;
    end
  end

  // Head decode from registered state only
  always_comb begin
    up_green         = 1'b0;
    down_green       = 1'b0;
    turn_green       = 1'b0;
    pedestrian_green = 1'b0;
    up_yellow        = 1'b0;
    down_yellow      = 1'b0;
    turn_yellow      = 1'b0;
    case (state)
      MAIN_GREEN:  begin up_green = 1'b1; down_green  = 1'b1; end
      DOWN_YELLOW: begin up_green = 1'b1; down_yellow = 1'b1; end
      TURN_GREEN:  begin up_green = 1'b1; turn_green  = 1'b1; end
      TURN_YELLOW: begin up_green = 1'b1; turn_yellow = 1'b1; end
      MAIN_YELLOW: begin up_yellow = 1'b1; down_yellow = 1'b1; end
      PED_WALK:    pedestrian_green = 1'b1;
      default:     ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_phase_scheduler.sv
module tb_phase_scheduler;

  localparam logic [2:0] S_MG  = 3'd0;
  localparam logic [2:0] S_DY  = 3'd1;
  localparam logic [2:0] S_TG  = 3'd2;
  localparam logic [2:0] S_TY  = 3'd3;
  localparam logic [2:0] S_MY  = 3'd4;
  localparam logic [2:0] S_ARI = 3'd5;
  localparam logic [2:0] S_PW  = 3'd6;
  localparam logic [2:0] S_ARO = 3'd7;

  logic       clock;
  logic       reset;
  logic       pedestrian_button;
  logic       turn_sensor;
  logic       up_green, down_green, turn_green, pedestrian_green;
  logic       up_yellow, down_yellow, turn_yellow;
  logic       ped_wait, turn_wait;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  phase_scheduler dut (
    .clock            (clock),
    .reset            (reset),
    .pedestrian_button(pedestrian_button),
    .turn_sensor      (turn_sensor),
    .up_green         (up_green),
    .down_green       (down_green),
    .turn_green       (turn_green),
    .pedestrian_green (pedestrian_green),
    .up_yellow        (up_yellow),
    .down_yellow      (down_yellow),
    .turn_yellow      (turn_yellow),
    .ped_wait         (ped_wait),
    .turn_wait        (turn_wait),
    .state_dbg        (state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected heads {up_g, down_g, turn_g, ped_g, up_y, down_y, turn_y}
  function automatic logic [6:0] heads_for(input logic [2:0] s);
    case (s)
      S_MG:    return 7'b1100000;
      S_DY:    return 7'b1000010;
      S_TG:    return 7'b1010000;
      S_TY:    return 7'b1000001;
      S_MY:    return 7'b0000110;
      S_PW:    return 7'b0001000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, landing 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_safety(input string tag);
    chk({tag, " ped_vs_main"}, {31'd0, pedestrian_green & (up_green | down_green)}, 32'd0);
    chk({tag, " turn_vs_down"}, {31'd0, turn_green & down_green}, 32'd0);
  endtask

  task automatic chk_cycle(input string tag, input logic [2:0] exp_s,
                           input logic exp_pw, input logic exp_tw);
    logic [6:0] heads;
    heads = {up_green, down_green, turn_green, pedestrian_green,
             up_yellow, down_yellow, turn_yellow};
    chk({tag, " state"}, {29'd0, state_dbg}, {29'd0, exp_s});
    chk({tag, " heads"}, {25'd0, heads}, {25'd0, heads_for(exp_s)});
    chk({tag, " ped_wait"}, {31'd0, ped_wait}, {31'd0, exp_pw});
    chk({tag, " turn_wait"}, {31'd0, turn_wait}, {31'd0, exp_tw});
    chk_safety(tag);
  endtask

  // Hold reset for n edges, checking the reset outputs. Returns in cycle 0.
  task automatic do_reset(input int n);
    reset = 1'b1;
    pedestrian_button = 1'b0;
    turn_sensor = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk_cycle($sformatf("reset%0d", i), S_MG, 1'b0, 1'b0);
    end
    reset = 1'b0;
  endtask

  // Pedestrian service timeline from cycle 0 with a request latched before cycle 7.
  function automatic logic [2:0] ped_path(input int c);
    if (c <= 7)  return S_MG;
    if (c <= 9)  return S_MY;
    if (c == 10) return S_ARI;
    if (c <= 16) return S_PW;
    if (c == 17) return S_ARO;
    return S_MG;
  endfunction

  function automatic logic [2:0] turn_path(input int c);
    if (c <= 7)  return S_MG;
    if (c <= 9)  return S_DY;
    if (c <= 13) return S_TG;
    if (c <= 15) return S_TY;
    return S_MG;
  endfunction

  initial begin
    reset = 1'b1;
    pedestrian_button = 1'b0;
    turn_sensor = 1'b0;

    // Reset values
    do_reset(3);

    // Pedestrian service: pulse at cycle 2
    for (int c = 0; c <= 20; c++) begin
      pedestrian_button = (c == 2);
      chk_cycle($sformatf("ped c%0d", c), ped_path(c), (c >= 3 && c <= 10), 1'b0);
      tick();
    end

    // Turn service: sensor high in cycle 0 only
    do_reset(1);
    for (int c = 0; c <= 18; c++) begin
      turn_sensor = (c == 0);
      chk_cycle($sformatf("turn c%0d", c), turn_path(c), 1'b0, (c >= 1 && c <= 9));
      tick();
    end
    turn_sensor = 1'b0;

    // Tie: pedestrian first (last_served starts at turn), then turn
    do_reset(1);
    for (int c = 0; c <= 33; c++) begin
      logic [2:0] exp_s;
      pedestrian_button = (c == 0);
      turn_sensor = (c == 0);
      if (c <= 17)      exp_s = ped_path(c);
      else if (c <= 25) exp_s = S_MG;
      else              exp_s = turn_path(c - 18);
      chk_cycle($sformatf("tie c%0d", c), exp_s, (c >= 1 && c <= 10), (c >= 1 && c <= 27));
      tick();
    end
    pedestrian_button = 1'b0;
    turn_sensor = 1'b0;

    // Button held through the whole walk and released after it: flag stays clear
    do_reset(1);
    for (int c = 0; c <= 27; c++) begin
      pedestrian_button = (c == 0) || (c >= 11 && c <= 16);
      chk_cycle($sformatf("own c%0d", c), ped_path(c), (c >= 1 && c <= 10), 1'b0);
      tick();
    end
    pedestrian_button = 1'b0;

    // Button held through the return to main green: re-latched and served again
    do_reset(1);
    for (int c = 0; c <= 26; c++) begin
      logic [2:0] exp_s;
      pedestrian_button = (c == 0) || (c >= 11 && c <= 18);
      exp_s = (c <= 25) ? ped_path(c) : S_MY;
      chk_cycle($sformatf("relatch c%0d", c), exp_s,
                (c >= 1 && c <= 10) || (c >= 18), 1'b0);
      tick();
    end
    pedestrian_button = 1'b0;

    // Mid-phase reset during PED_WALK (cycle 13)
    do_reset(1);
    for (int c = 0; c <= 13; c++) begin
      pedestrian_button = (c == 2);
      reset = (c == 13);
      chk_cycle($sformatf("midrst c%0d", c), ped_path(c), (c >= 3 && c <= 10), 1'b0);
      tick();
    end
    reset = 1'b0;
    for (int c = 14; c <= 23; c++) begin
      chk_cycle($sformatf("midrst c%0d", c), S_MG, 1'b0, 1'b0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
